// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one single-port, byte-addressed,
// big-endian data memory between port 0 (CPU load/store) and port 1 (debug/loader DMA).
// Each port uses a req/ack handshake. A request is granted at a clock edge and is
// serviced in the following cycle, in which ack pulses for one cycle.
//
// Optional build macro DMEM_ARB_CHECK_EN: misaligned or out-of-range accesses are
// still acked, but with err=1, no memory write and rdata=0.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | no access in flight; memory pins held at 0
// SERVE0 | port 0 owns the memory this cycle; m0_ack=1
// SERVE1 | port 1 owns the memory this cycle; m1_ack=1

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    if (MEM_BYTES < 4) begin : g_cfg_err
        $error("dmem_arbiter: MEM_BYTES must be at least one word");
    end

    state_t state;
    logic   rr_ptr;
    logic   pick1;
    logic   bad0;
    logic   bad1;

    // Tie-break owner: the port just served loses, so continuous contention alternates.
    always_comb begin
        pick1 = rr_ptr;
        if (state == SERVE0) pick1 = 1'b1;
        else if (state == SERVE1) pick1 = 1'b0;
    end

`ifdef DMEM_ARB_CHECK_EN
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    // Flag accesses that are not word aligned or that run past the end of memory.
    always_comb begin
        bad0 = (m0_addr[1:0] != 2'b00) || (m0_addr > LAST_WORD);
        bad1 = (m1_addr[1:0] != 2'b00) || (m1_addr > LAST_WORD);
    end
`else
    // Range checking is compiled out; every address passes through.
    always_comb begin
        bad0 = 1'b0;
        bad1 = 1'b0;
    end
`endif

    // Grant decision and round-robin pointer, evaluated at every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            if (m0_req && m1_req) state <= pick1 ? SERVE1 : SERVE0;
            else if (m0_req)      state <= SERVE0;
            else if (m1_req)      state <= SERVE1;
            else                  state <= IDLE;

            case (state)
                SERVE0:  rr_ptr <= 1'b1;
                SERVE1:  rr_ptr <= 1'b0;
                default: rr_ptr <= rr_ptr;
            endcase
        end
    end

    // Memory pins and port responses decode from state, so reset kills them at once.
    always_comb begin
        mem_a    = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        m0_ack   = 1'b0;
        m0_rdata = '0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_rdata = '0;
        m1_err   = 1'b0;
        case (state)
            SERVE0: begin
                mem_a  = m0_addr;
                mem_wd = m0_wdata;
                mem_we = m0_we && !bad0;
                m0_ack = 1'b1;
                m0_err = bad0;
                if (!m0_we && !bad0) m0_rdata = mem_rd;
            end
            SERVE1: begin
                mem_a  = m1_addr;
                mem_wd = m1_wdata;
                mem_we = m1_we && !bad1;
                m1_ack = 1'b1;
                m1_err = bad1;
                if (!m1_we && !bad1) m1_rdata = mem_rd;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a 256-byte big-endian memory attached.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              m0_req, m0_we, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd, mem_rd;
    logic              mem_we;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];

    dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian memory: lowest address holds the most significant byte.
    always_comb begin
        logic [7:0] ba;
        ba = mem_a[7:0];
        mem_rd = {mem[ba], mem[8'(ba + 8'd1)], mem[8'(ba + 8'd2)], mem[8'(ba + 8'd3)]};
    end

    always @(posedge clk) begin
        logic [7:0] ba;
        ba = mem_a[7:0];
        if (mem_we) begin
            mem[ba]             <= mem_wd[31:24];
            mem[8'(ba + 8'd1)]  <= mem_wd[23:16];
            mem[8'(ba + 8'd2)]  <= mem_wd[15:8];
            mem[8'(ba + 8'd3)]  <= mem_wd[7:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Port 0 single request; leaves the caller in the first ack cycle.
    task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        tick();
    endtask

    // Request held through the ack cycle re-enters service once; then go idle.
    task automatic finish0();
        tick();
        m0_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drop_all();
        m0_we = 0; m1_we = 0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        repeat (3) tick();
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {m0_ack, m1_ack, m0_err, m1_err, mem_we});
        end
        checks++;
        if ({mem_a, mem_wd, m0_rdata, m1_rdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {mem_a, mem_wd, m0_rdata, m1_rdata});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [5:0] order;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h44;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ((m0_ack ^ m1_ack) !== 1'b1) begin
                failures++;
                $display("FAIL contention_one_ack cycle=%0d got=%b%b want=exactly one", i, m0_ack, m1_ack);
            end
            order[i] = m1_ack;
        end
        checks++;
        if (order !== 6'b101010) begin
            failures++;
            $display("FAIL contention_order got=%b want=101010 (bit0 first)", order);
        end
        drop_all();
        tick();
        checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            failures++;
            $display("FAIL contention_release got=%b want=00", {m0_ack, m1_ack});
        end
    endtask

    task automatic test_port0_alone();
        req0(1'b1, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({m0_ack, m1_ack, mem_we, m0_err} !== 4'b1010) begin
            failures++;
            $display("FAIL p0_write_ctrl got=%b want=1010", {m0_ack, m1_ack, mem_we, m0_err});
        end
        checks++;
        if (mem_a !== 32'h10 || mem_wd !== 32'hDEADBEEF || m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL p0_write_bus got a=%h wd=%h rd=%h want 10 deadbeef 0", mem_a, mem_wd, m0_rdata);
        end
        finish0();
        req0(1'b0, 32'h10, 32'h0);
        checks++;
        if (m0_ack !== 1'b1 || mem_we !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL p0_read got ack=%b we=%b rd=%h want 1 0 deadbeef", m0_ack, mem_we, m0_rdata);
        end
        finish0();
    endtask

    task automatic test_back_to_back();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        tick();
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h20) begin
            failures++;
            $display("FAIL b2b_write got ack1=%b ack0=%b we=%b a=%h want 1 0 1 20", m1_ack, m0_ack, mem_we, mem_a);
        end
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'h12345678 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL b2b_read got ack0=%b ack1=%b rd0=%h rd1=%h want 1 0 12345678 0", m0_ack, m1_ack, m0_rdata, m1_rdata);
        end
        m1_req = 0;
        finish0();
    endtask

    task automatic test_reset_mid_serve();
        m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hA5A5A5A5;
        tick();
        checks++;
        if (m1_ack !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got ack1=%b we=%b want 1 1", m1_ack, mem_we);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (m1_ack !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async got ack1=%b we=%b want 0 0", m1_ack, mem_we);
        end
        drop_all();
        m1_we = 0;
        tick();
        reset = 1'b0;
        tick();
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h44;
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_rr_ptr got ack0=%b ack1=%b want 1 0", m0_ack, m1_ack);
        end
        drop_all();
        tick();
        tick();
        req0(1'b0, 32'h30, 32'h0);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_no_write got ack=%b rd=%h want 1 00000000", m0_ack, m0_rdata);
        end
        finish0();
    endtask

    task automatic test_idle();
        drop_all();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({mem_we, m0_ack, m1_ack} !== 3'b000) begin
                failures++;
                $display("FAIL idle cycle=%0d got=%b want=000", i, {mem_we, m0_ack, m1_ack});
            end
        end
    endtask

    task automatic test_check();
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_word;
`ifdef DMEM_ARB_CHECK_EN
        exp_err  = 1'b1;
        exp_we   = 1'b0;
        exp_word = 32'h12345678;
`else
        exp_err  = 1'b0;
        exp_we   = 1'b1;
        exp_word = 32'h12CAFEF0;
`endif
        req0(1'b1, 32'h21, 32'hCAFEF00D);
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== exp_err || mem_we !== exp_we || m1_err !== 1'b0) begin
            failures++;
            $display("FAIL chk_misaligned got ack=%b err=%b we=%b err1=%b want 1 %b %b 0", m0_ack, m0_err, mem_we, m1_err, exp_err, exp_we);
        end
        finish0();
        req0(1'b1, 32'hFD, 32'h01020304);
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== exp_err || mem_we !== exp_we) begin
            failures++;
            $display("FAIL chk_range got ack=%b err=%b we=%b want 1 %b %b", m0_ack, m0_err, mem_we, exp_err, exp_we);
        end
        finish0();
        req0(1'b0, 32'h20, 32'h0);
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== exp_word) begin
            failures++;
            $display("FAIL chk_mem_after got ack=%b err=%b rd=%h want 1 0 %h", m0_ack, m0_err, m0_rdata, exp_word);
        end
        finish0();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_contention();
        test_port0_alone();
        test_back_to_back();
        test_reset_mid_serve();
        test_idle();
        test_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed, big-endian data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/loader DMA).
- Uses a req/ack handshake on each port with round-robin arbitration.
- Drives the memory's address, write-data and write-enable pins and returns read data to the granted port.
- Sits between the requesters and the data memory; it is the only driver of the memory's a/wd/we.

Parameters:
- ADDR_W, 32, width of requester and memory address buses.
- MEM_BYTES, 256, memory size in bytes; used for range checking.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  port 0 request; held high until m0_ack.
- m0_we  input  1  port 0 write (1) / read (0).
- m0_addr  input  ADDR_W  port 0 byte address.
- m0_wdata  input  32  port 0 write data.
- m0_ack  output  1  one-cycle completion pulse for port 0.
- m0_rdata  output  32  port 0 read data, valid while m0_ack=1.
- m0_err  output  1  error flag, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as the port 0 signals, for port 1.
- mem_a  output  ADDR_W  memory address.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  32  memory combinational read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0 (port 0 favoured), all ack/err=0, mem_we=0, mem_a=0, mem_wd=0, rdata=0.
- States: IDLE, SERVE0, SERVE1. State, owner and rr_ptr are registered.
- State transitions, evaluated at each rising edge:
  - Only one of m0_req/m1_req high: go to that port's SERVE state.
  - Both high: go to SERVE(rr_ptr).
  - Neither high: go to IDLE.
  - These rules apply equally from IDLE and from SERVEx, so back-to-back service with no idle gap is allowed.
- In SERVEx:
  - mem_a = mx_addr, mem_wd = mx_wdata, mem_we = mx_we. The memory write commits at the edge that ends the cycle.
  - mx_ack=1.
  - mx_rdata = mem_rd combinationally for reads; 0 for writes.
  - rr_ptr <= ~x at the cycle-end edge.
- Outside SERVEx, mx_ack=0 and mx_rdata=0.
- Latency: req first high in cycle N, port uncontended → ack in cycle N+1.
- Fairness: under contention, the worst-case wait is one foreign service, so ack comes no later than N+2.
- Handshake: the requester must hold req/we/addr/wdata stable until the ack cycle inclusive. If req is still high in the cycle after ack, it is a new request.
- Dropping req before ack is illegal. The block behaves as follows: if req is low at the decision edge, that port is not served and no memory access occurs.
- Simultaneous events: both ports requesting continuously yields strict alternation 0,1,0,1… starting from rr_ptr.
- Reset mid-operation: mem_we and ack fall to 0 immediately and asynchronously (they are decoded from state), so no write commits at the following edge. rr_ptr returns to 0.
- Addressing: the address is passed through unmodified; the memory is big-endian, so mem_a holds the MSB byte.

Optional Feature:
- Macro: DMEM_ARB_CHECK_EN.
- With DMEM_ARB_CHECK_EN defined:
  - An access with addr[1:0]≠0 or addr > MEM_BYTES-4 is still granted and acked in the normal cycle.
  - mem_we is forced to 0 (no memory write), rdata=0, and mx_err=1 with the ack.
  - Arbitration and rr_ptr update are unchanged.
- Without the macro: m0_err=m1_err=0 always, and all addresses pass unchecked.

Test Plan:
- Port 0 alone: m0_req=1, we=1, addr=0x10, wdata=0xDEADBEEF → m0_ack one cycle later with mem_we=1, mem_a=0x10. Then a read of 0x10 → m0_rdata=0xDEADBEEF with ack.
- Both ports request at the same edge after reset, each holding req → port 0 acked in cycle N+1, port 1 in N+2. With both holding req for 6 cycles → ack order 0,1,0,1,0,1.
- Port 1 write 0x12345678 to 0x20 back-to-back with a port 0 read of 0x20 → port 0 reads 0x12345678; no idle cycle between the two acks.
- Assert reset asynchronously mid-SERVE1 write to 0x30 (prior value 0) → mem_we and m1_ack drop before the next edge; 0x30 reads 0 after reset; the next contended grant goes to port 0.
- Idle: no req for 5 cycles → mem_we=0, both acks 0 throughout.
- With DMEM_ARB_CHECK_EN: port 0 write to 0x21, then to 0xFD → each acked with m0_err=1 and mem_we=0, memory unchanged. Without the macro: m0_err stays 0.
